serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; SHALL be an even value of at least 4.
REQ-002 Parameter DATA_W, default 8, meaning data bits per frame.
REQ-003 Parameter PARITY_EN, default 1, meaning an even-parity bit is present after the data bits.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_1, input, 1 bit: serial line, idle high.
REQ-007 Port out_data, output, DATA_W bits: last correctly received data word.
REQ-008 Port out_valid, output, 1 bit: one-cycle pulse when out_data updates.
REQ-009 Port out_err, output, 1 bit: one-cycle pulse on a parity or framing error.
REQ-010 Port out_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 in_1 SHALL pass through a two-flop synchronizer; "s" below means the synchronized line, which lags in_1 by 2 cycles.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; a bit counter SHALL count 0..CLKS_PER_BIT-1.
REQ-013 IDLE: when s==0, go to START with the counter cleared.
REQ-014 START: at counter == CLKS_PER_BIT/2-1, if s==0 go to DATA (counter cleared, bit index 0); if s==1 it is a glitch, so return to IDLE with no error.
REQ-015 DATA: at counter == CLKS_PER_BIT-1, sample s into bit[index] (LSB first) and clear the counter; after the bit DATA_W-1 sample, go to PARITY if PARITY_EN, else STOP.
REQ-016 PARITY: at counter == CLKS_PER_BIT-1, sample s; a parity error SHALL be flagged if s != XOR of the received data bits.
REQ-017 STOP: at counter == CLKS_PER_BIT-1, sample s.
REQ-018 STOP with s==1 and no parity error: on the next edge, load out_data, pulse out_valid, go to IDLE.
REQ-019 STOP with s==1 and a parity error: on the next edge, pulse out_err, leave out_data unchanged, go to IDLE.
REQ-020 STOP with s==0 (framing error): on the next edge, pulse out_err and go to WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until s==1, then go to IDLE; no further out_err pulses.
REQ-022 out_valid and out_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-023 A new start bit SHALL be accepted in the cycle after the STOP-to-IDLE transition; back-to-back frames with no idle gap SHALL be received.
REQ-024 out_data SHALL hold its value between valid frames.

Reset
REQ-025 While rst is high: state IDLE, counter and bit index 0, shift register 0, synchronizer flops 1, out_data 0, out_valid 0, out_err 0, out_busy 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no out_valid or out_err.
REQ-027 After reset release, the line idling high SHALL NOT start a frame.

Structure
REQ-028 The state encoding constants and parameter defaults SHALL live in shared package serial_rx_pkg.
REQ-029 The synchronizer SHALL be sub-module sync_dflop (two flops, reset value 1); the FSM, counter and shift register SHALL be in serial_frame_rx.

Verification (CLKS_PER_BIT=4, DATA_W=8, PARITY_EN=1)
REQ-030 Frame 0xA5, parity 0, stop 1 -> one out_valid pulse, out_data=0xA5, out_err=0.
REQ-031 in_1 low for 1 cycle, then high -> out_busy pulses briefly, no out_valid, no out_err, returns to IDLE.
REQ-032 Frame 0x01 with parity 0 after 0xA5 -> one out_err pulse, out_data stays 0xA5.
REQ-033 Frame 0x3C with stop 0, line held low for 20 cycles -> one out_err, out_busy high until line goes high; next frame 0x3C -> out_data=0x3C.
REQ-034 rst pulsed during data bit 3 of 0x55 -> all outputs 0, no pulses; next frame 0xFF -> out_data=0xFF.
REQ-035 Frames 0x00 and 0xFF back-to-back -> two out_valid pulses, 11*4 cycles apart, data 0x00 then 0xFF.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared state encoding and parameter defaults for the serial frame receiver.
package serial_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_PARITY_EN    = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

endpackage

// File: rtl/sync_dflop.sv
// Two-flop synchronizer for the idle-high serial line; resets to the idle level.
module sync_dflop (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_err,
  output logic              out_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                par_err, par_err_nxt;
  logic                valid_nxt, err_nxt;
  logic                s;

  sync_dflop u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_1),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par_err   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      par_err   <= par_err_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    par_err_nxt = par_err;
    data_nxt    = out_data;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (!s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      // Start bit is re-checked at mid-bit so a short low glitch is dropped silently.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!s) begin
            state_nxt   = DATA;
            idx_nxt     = '0;
            par_err_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_nxt[idx] = s;
          cnt_nxt        = '0;
          if (idx == IDX_LAST) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          par_err_nxt = (s != (^shreg));
          cnt_nxt     = '0;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Returning straight to IDLE here lets a start bit that follows the stop bit be caught.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (!s) begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_IDLE;
          end else if (par_err) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            valid_nxt = 1'b1;
            data_nxt  = shreg;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign out_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx with directed scenarios and a random frame stream.
module tb_serial_frame_rx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_1 = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid, out_err, out_busy;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;
  logic [8:0] ev_q[$];
  int vtime_q[$];
  logic [DW-1:0] model_data;

  serial_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_1     (in_1),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_err  (out_err),
    .out_busy (out_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log: {is_err, data}; error events carry zero data.
  always @(negedge clk) begin
    if (out_valid) begin
      valid_cnt = valid_cnt + 1;
      ev_q.push_back({1'b0, out_data});
      vtime_q.push_back(cyc);
    end
    if (out_err) begin
      err_cnt = err_cnt + 1;
      ev_q.push_back({1'b1, 8'h00});
    end
    if (out_valid && out_err) both_cnt = both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    in_1 = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", out_busy); end
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_busy) seen++;
      end
      checks++; if (seen != 0 || ev_q.size() != 0) begin errors++; $display("FAIL idle_after_reset busy_cycles %0d events %0d want 0 0", seen, ev_q.size()); end
    end
  endtask

  task automatic test_valid_frame();
    int v0 = valid_cnt, e0 = err_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(8);
    model_data = 8'hA5;
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a5_valid_pulses got %0d want 1", valid_cnt - v0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL a5_err_pulses got %0d want 0", err_cnt - e0); end
    checks++; if (out_data !== model_data) begin errors++; $display("FAIL a5_data got %h want %h", out_data, model_data); end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt, e0 = err_cnt, seen = 0;
    in_1 = 1'b0;
    @(negedge clk);
    in_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_busy) seen++;
    end
    checks++; if (seen < 1 || seen > 3) begin errors++; $display("FAIL glitch_busy_cycles got %0d want 1..3", seen); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy %b want 0", out_busy); end
    checks++; if (valid_cnt != v0 || err_cnt != e0) begin errors++; $display("FAIL glitch_pulses got v%0d e%0d want 0 0", valid_cnt - v0, err_cnt - e0); end
  endtask

  task automatic test_parity_err();
    int v0 = valid_cnt, e0 = err_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    idle(8);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_err_pulses got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL parity_valid_pulses got %0d want 0", valid_cnt - v0); end
    checks++; if (out_data !== model_data) begin errors++; $display("FAIL parity_data got %h want %h", out_data, model_data); end
  endtask

  task automatic test_framing();
    int v0 = valid_cnt, e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL framing_err_pulses got %0d want 1", err_cnt - e0); end
    checks++; if (out_busy !== 1'b1) begin errors++; $display("FAIL framing_busy_low got %b want 1", out_busy); end
    in_1 = 1'b1;
    idle(6);
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL framing_busy_high got %b want 0", out_busy); end
    checks++; if (err_cnt - e0 != 1 || valid_cnt != v0) begin errors++; $display("FAIL framing_pulses got e%0d v%0d want 1 0", err_cnt - e0, valid_cnt - v0); end
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(8);
    model_data = 8'h3C;
    checks++; if (out_data !== model_data || valid_cnt - v0 != 1) begin errors++; $display("FAIL framing_recover got %h/%0d want %h/1", out_data, valid_cnt - v0, model_data); end
  endtask

  task automatic test_reset_midframe();
    int v0, e0;
    logic [DW-1:0] d = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    in_1 = d[3];
    idle(2);
    v0 = valid_cnt; e0 = err_cnt;
    rst = 1'b1;
    in_1 = 1'b1;
    idle(1);
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", out_data); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", out_busy); end
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses got v%b e%b want 0 0", out_valid, out_err); end
    idle(2);
    rst = 1'b0;
    model_data = 8'h00;
    idle(50);
    checks++; if (valid_cnt != v0 || err_cnt != e0) begin errors++; $display("FAIL midrst_abort got v%0d e%0d want 0 0", valid_cnt - v0, err_cnt - e0); end
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(8);
    model_data = 8'hFF;
    checks++; if (out_data !== model_data || valid_cnt - v0 != 1) begin errors++; $display("FAIL midrst_next got %h/%0d want %h/1", out_data, valid_cnt - v0, model_data); end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt, e0 = err_cnt, b0 = ev_q.size(), t0 = vtime_q.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(8);
    model_data = 8'hFF;
    checks++; if (valid_cnt - v0 != 2 || err_cnt != e0) begin errors++; $display("FAIL b2b_pulses got v%0d e%0d want 2 0", valid_cnt - v0, err_cnt - e0); end
    if (ev_q.size() >= b0 + 2 && vtime_q.size() >= t0 + 2) begin
      checks++; if (ev_q[b0] !== 9'h000) begin errors++; $display("FAIL b2b_first got %h want 000", ev_q[b0]); end
      checks++; if (ev_q[b0+1] !== 9'h0FF) begin errors++; $display("FAIL b2b_second got %h want 0ff", ev_q[b0+1]); end
      checks++; if (vtime_q[t0+1] - vtime_q[t0] != 11 * CPB) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", vtime_q[t0+1] - vtime_q[t0], 11 * CPB); end
    end else begin
      checks++; errors++; $display("FAIL b2b_events got %0d want 2", ev_q.size() - b0);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    int base = ev_q.size();
    int n;
    for (int k = 0; k < 24; k++) begin
      logic [DW-1:0] d = DW'($urandom);
      logic par = (^d) ^ ($urandom_range(0, 3) == 0);
      logic stp = ($urandom_range(0, 4) != 0);
      send_frame(d, par, stp);
      if (!stp || par != (^d)) exp_q.push_back({1'b1, 8'h00});
      else begin
        exp_q.push_back({1'b0, d});
        model_data = d;
      end
      if (!stp) begin
        idle(8);
        in_1 = 1'b1;
        idle(3 * CPB);
      end else begin
        idle($urandom_range(0, 6));
      end
    end
    idle(12);
    n = ev_q.size() - base;
    checks++; if (n != exp_q.size()) begin errors++; $display("FAIL rand_event_count got %0d want %0d", n, exp_q.size()); end
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL rand_event_%0d got %h want %h", i, ev_q[base+i], exp_q[i]); end
    end
    checks++; if (out_data !== model_data) begin errors++; $display("FAIL rand_final_data got %h want %h", out_data, model_data); end
  endtask

  initial begin
    model_data = 8'h00;
    test_reset();
    test_valid_frame();
    test_glitch();
    test_parity_err();
    test_framing();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_err_overlap got %0d want 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
